// File: rtl/ucaspian_dendrite.sv
`default_nettype none
// ============================================================================
// Module   : ucaspian_dendrite
// Brief    : Per-neuron charge accumulator. Sums signed synapse weights into a
//            256-entry accumulator RAM during a time step, then on next_step
//            drains every non-zero entry to the neuron block over a
//            valid/ready link, zeroing entries as they go.
// Options  : UCASPIAN_DENDRITE_SAT_EN - saturating accumulate (default: wrap)
// Revision : 1.0 - initial release
// ============================================================================
module ucaspian_dendrite #(
  parameter int WEIGHT_W = 8,
  parameter int CHARGE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear_act,
  output logic                       clear_done,
  input  logic                       next_step,
  output logic                       step_done,
  input  logic [7:0]                 syn_addr,
  input  logic signed [WEIGHT_W-1:0] syn_weight,
  input  logic                       syn_vld,
  output logic                       syn_rdy,
  output logic [7:0]                 neuron_addr,
  output logic signed [CHARGE_W-1:0] neuron_charge,
  output logic                       neuron_vld,
  input  logic                       neuron_rdy
);

  typedef enum logic [2:0] {
    ST_ACCUM      = 3'd0,
    ST_ACC_RD     = 3'd1,
    ST_ACC_WR     = 3'd2,
    ST_DRAIN_RD   = 3'd3,
    ST_DRAIN_CHK  = 3'd4,
    ST_DRAIN_SEND = 3'd5,
    ST_CLEAR      = 3'd6
  } state_t;

  localparam logic [7:0] c_last_addr = 8'hFF;

  state_t                       r_state, w_state_n;
  logic [7:0]                   r_scan, w_scan_n;
  logic                         r_pend, w_pend_n;
  logic [7:0]                   r_addr, w_addr_n;
  logic signed [WEIGHT_W-1:0]   r_wgt, w_wgt_n;
  logic                         r_nvld, w_nvld_n;
  logic [7:0]                   r_naddr, w_naddr_n;
  logic signed [CHARGE_W-1:0]   r_ncharge, w_ncharge_n;
  logic                         r_sdone, w_sdone_n;
  logic                         r_swept, w_swept_n;

  logic signed [CHARGE_W-1:0]   r_mem [256];
  logic signed [CHARGE_W-1:0]   r_rd_data;
  logic                         w_rd_en, w_wr_en;
  logic [7:0]                   w_rd_addr, w_wr_addr;
  logic signed [CHARGE_W-1:0]   w_wr_data;

  logic signed [CHARGE_W-1:0]   w_wext, w_raw, w_sum;
  logic                         w_accept;

  assign w_wext = {{(CHARGE_W-WEIGHT_W){r_wgt[WEIGHT_W-1]}}, r_wgt};
  assign w_raw  = r_rd_data + w_wext;

`ifdef UCASPIAN_DENDRITE_SAT_EN
  localparam logic signed [CHARGE_W-1:0] c_max = {1'b0, {(CHARGE_W-1){1'b1}}};
  localparam logic signed [CHARGE_W-1:0] c_min = {1'b1, {(CHARGE_W-1){1'b0}}};
  logic w_ovf;
  // Overflow only when both operands share a sign the result does not.
  assign w_ovf = (r_rd_data[CHARGE_W-1] == w_wext[CHARGE_W-1]) &&
                 (w_raw[CHARGE_W-1] != r_rd_data[CHARGE_W-1]);
  assign w_sum = w_ovf ? (r_rd_data[CHARGE_W-1] ? c_min : c_max) : w_raw;
`else
  assign w_sum = w_raw;
`endif

  // Ready only while idle-accumulating; reset and clear take priority.
  assign syn_rdy  = !reset && enable && !clear_act && (r_state == ST_ACCUM) && !r_pend;
  assign w_accept = syn_vld && syn_rdy;

  assign clear_done    = r_swept;
  assign step_done     = r_sdone;
  assign neuron_vld    = r_nvld;
  assign neuron_addr   = r_naddr;
  assign neuron_charge = r_ncharge;

  // Accumulator RAM: one synchronous read port, one synchronous write port.
  always_ff @(posedge clk) begin
    if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_ACCUM;
      r_scan    <= '0;
      r_pend    <= 1'b0;
      r_addr    <= '0;
      r_wgt     <= '0;
      r_nvld    <= 1'b0;
      r_naddr   <= '0;
      r_ncharge <= '0;
      r_sdone   <= 1'b0;
      r_swept   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_scan    <= w_scan_n;
      r_pend    <= w_pend_n;
      r_addr    <= w_addr_n;
      r_wgt     <= w_wgt_n;
      r_nvld    <= w_nvld_n;
      r_naddr   <= w_naddr_n;
      r_ncharge <= w_ncharge_n;
      r_sdone   <= w_sdone_n;
      r_swept   <= w_swept_n;
    end
  end

  // Next-state, RAM port control and output updates.
  always_comb begin
    w_state_n   = r_state;
    w_scan_n    = r_scan;
    w_pend_n    = r_pend;
    w_addr_n    = r_addr;
    w_wgt_n     = r_wgt;
    w_nvld_n    = r_nvld;
    w_naddr_n   = r_naddr;
    w_ncharge_n = r_ncharge;
    w_sdone_n   = 1'b0;
    w_swept_n   = r_swept;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_scan;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_scan;
    w_wr_data   = '0;

    if (reset) begin
      // Registers reload from reset; keep the RAM ports quiet.
      w_rd_en = 1'b0;
    end else if (clear_act) begin
      if (r_state != ST_CLEAR) begin
        w_state_n = ST_CLEAR;
        w_scan_n  = '0;
        w_swept_n = 1'b0;
        w_pend_n  = 1'b0;
        w_nvld_n  = 1'b0;
      end else if (!r_swept) begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_scan;
        if (r_scan == c_last_addr) w_swept_n = 1'b1;
        else                       w_scan_n  = r_scan + 8'd1;
      end
    end else if (r_state == ST_CLEAR) begin
      w_state_n = ST_ACCUM;
      w_swept_n = 1'b0;
    end else if (enable) begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept && (syn_weight != '0)) begin
            w_rd_en   = 1'b1;
            w_rd_addr = syn_addr;
            w_addr_n  = syn_addr;
            w_wgt_n   = syn_weight;
            w_state_n = ST_ACC_RD;
            if (next_step) w_pend_n = 1'b1;
          end else if (next_step) begin
            w_scan_n  = '0;
            w_state_n = ST_DRAIN_RD;
          end
        end
        ST_ACC_RD: begin
          if (next_step) w_pend_n = 1'b1;
          w_state_n = ST_ACC_WR;
        end
        ST_ACC_WR: begin
          w_wr_en   = 1'b1;
          w_wr_addr = r_addr;
          w_wr_data = w_sum;
          if (r_pend || next_step) begin
            w_pend_n  = 1'b1;
            w_scan_n  = '0;
            w_state_n = ST_DRAIN_RD;
          end else begin
            w_state_n = ST_ACCUM;
          end
        end
        ST_DRAIN_RD: begin
          w_rd_en   = 1'b1;
          w_rd_addr = r_scan;
          w_state_n = ST_DRAIN_CHK;
        end
        ST_DRAIN_CHK: begin
          if (r_rd_data != '0) begin
            w_nvld_n    = 1'b1;
            w_naddr_n   = r_scan;
            w_ncharge_n = r_rd_data;
            w_state_n   = ST_DRAIN_SEND;
          end else if (r_scan == c_last_addr) begin
            w_sdone_n = 1'b1;
            w_pend_n  = 1'b0;
            w_state_n = ST_ACCUM;
          end else begin
            w_scan_n  = r_scan + 8'd1;
            w_state_n = ST_DRAIN_RD;
          end
        end
        ST_DRAIN_SEND: begin
          if (neuron_rdy) begin
            w_nvld_n  = 1'b0;
            w_wr_en   = 1'b1;
            w_wr_addr = r_scan;
            if (r_scan == c_last_addr) begin
              w_sdone_n = 1'b1;
              w_pend_n  = 1'b0;
              w_state_n = ST_ACCUM;
            end else begin
              w_scan_n  = r_scan + 8'd1;
              w_state_n = ST_DRAIN_RD;
            end
          end
        end
        default: w_state_n = ST_ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ucaspian_dendrite.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucaspian_dendrite
// Brief    : Directed self-checking bench for ucaspian_dendrite.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucaspian_dendrite;

  logic              clk = 1'b0;
  logic              reset, enable, clear_act, next_step, syn_vld, neuron_rdy;
  logic [7:0]        syn_addr;
  logic signed [7:0] syn_weight;
  logic              clear_done, step_done, syn_rdy, neuron_vld;
  logic [7:0]        neuron_addr;
  logic signed [15:0] neuron_charge;

  int tests = 0;
  int fails = 0;
  int n_xfer, drain_cyc;
  logic [7:0]         got_addr [8];
  logic signed [15:0] got_chg  [8];

`ifdef UCASPIAN_DENDRITE_SAT_EN
  localparam int EXP_SAT = 32767;
`else
  localparam int EXP_SAT = -27436;
`endif

  ucaspian_dendrite #(.WEIGHT_W(8), .CHARGE_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_act(clear_act), .clear_done(clear_done),
    .next_step(next_step), .step_done(step_done),
    .syn_addr(syn_addr), .syn_weight(syn_weight),
    .syn_vld(syn_vld), .syn_rdy(syn_rdy),
    .neuron_addr(neuron_addr), .neuron_charge(neuron_charge),
    .neuron_vld(neuron_vld), .neuron_rdy(neuron_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic signed [7:0] w);
    logic ok;
    ok = 1'b0;
    syn_addr = a; syn_weight = w; syn_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (syn_rdy) begin
        ok = 1'b1;
        tick;
        break;
      end
      tick;
    end
    syn_vld = 1'b0;
    check("send_accepted", {31'd0, ok}, 1);
  endtask

  task automatic pulse_step;
    next_step = 1'b1;
    tick;
    next_step = 1'b0;
  endtask

  // Observe transfers until step_done, then confirm it is a single pulse.
  task automatic drain(input int budget);
    n_xfer = 0;
    drain_cyc = 0;
    while (!step_done && drain_cyc < budget) begin
      if (neuron_vld && neuron_rdy) begin
        if (n_xfer < 8) begin
          got_addr[n_xfer] = neuron_addr;
          got_chg[n_xfer]  = neuron_charge;
        end
        n_xfer++;
      end
      tick;
      drain_cyc++;
    end
    check("step_done_seen", {31'd0, step_done}, 1);
    tick;
    check("step_done_pulse", {31'd0, step_done}, 0);
  endtask

  task automatic wait_vld;
    for (int i = 0; i < 600; i++) begin
      if (neuron_vld) break;
      tick;
    end
    check("neuron_vld_rise", {31'd0, neuron_vld}, 1);
  endtask

  task automatic do_clear(input int exp_cycles);
    int cyc;
    logic sd_seen;
    cyc = 0;
    sd_seen = 1'b0;
    clear_act = 1'b1;
    while (!clear_done && cyc < 400) begin
      tick;
      cyc++;
      sd_seen |= step_done;
    end
    check("clear_cycles", cyc, exp_cycles);
    check("clear_no_step_done", {31'd0, sd_seen}, 0);
    check("clear_syn_rdy", {31'd0, syn_rdy}, 0);
    clear_act = 1'b0;
    tick;
    check("clear_done_fall", {31'd0, clear_done}, 0);
  endtask

  initial begin
    logic stable;
    reset = 1'b1; enable = 1'b0; clear_act = 1'b0; next_step = 1'b0;
    syn_vld = 1'b0; syn_addr = '0; syn_weight = '0; neuron_rdy = 1'b0;
    tick; tick;
    check("rst_syn_rdy", {31'd0, syn_rdy}, 0);
    check("rst_neuron_vld", {31'd0, neuron_vld}, 0);
    check("rst_step_done", {31'd0, step_done}, 0);
    check("rst_clear_done", {31'd0, clear_done}, 0);
    reset = 1'b0;
    tick;
    check("disabled_syn_rdy", {31'd0, syn_rdy}, 0);
    enable = 1'b1;
    #0;
    check("enabled_syn_rdy", {31'd0, syn_rdy}, 1);

    // Clear sweep: one cycle to enter, 256 writes, then clear_done.
    do_clear(257);
    check("post_clear_syn_rdy", {31'd0, syn_rdy}, 1);

    // Accumulation and ascending drain order.
    send(8'd5, 8'sd10);
    send(8'd5, -8'sd3);
    send(8'd200, 8'sd7);
    send(8'd0, 8'sd1);
    neuron_rdy = 1'b1;
    pulse_step;
    drain(2000);
    check("order_count", n_xfer, 3);
    check("order_a0", got_addr[0], 0);   check("order_c0", got_chg[0], 1);
    check("order_a1", got_addr[1], 5);   check("order_c1", got_chg[1], 7);
    check("order_a2", got_addr[2], 200); check("order_c2", got_chg[2], 7);

    // Empty array: no transfers, step_done 512 cycles after next_step.
    pulse_step;
    drain(2000);
    check("empty_count", n_xfer, 0);
    check("empty_latency", drain_cyc, 512);

    // Cancellation leaves a zero entry that is skipped.
    send(8'd3, 8'sd50);
    send(8'd3, -8'sd50);
    pulse_step;
    drain(2000);
    check("cancel_count", n_xfer, 0);

    // 300 x 127 = 38100 exceeds the 16-bit range.
    for (int i = 0; i < 300; i++) send(8'd9, 8'sd127);
    pulse_step;
    drain(2000);
    check("sat_count", n_xfer, 1);
    check("sat_addr", got_addr[0], 9);
    check("sat_charge", got_chg[0], EXP_SAT);

    // Backpressure: held stable for 20 cycles, then one transfer.
    neuron_rdy = 1'b0;
    send(8'd17, 8'sd4);
    pulse_step;
    wait_vld;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stable &= neuron_vld && (neuron_addr == 8'd17) &&
                (neuron_charge == 16'sd4) && !step_done;
      tick;
    end
    check("bp_stable", {31'd0, stable}, 1);
    neuron_rdy = 1'b1;
    drain(2000);
    check("bp_count", n_xfer, 1);
    check("bp_addr", got_addr[0], 17);
    check("bp_charge", got_chg[0], 4);
    pulse_step;
    drain(2000);
    check("bp_zeroed", n_xfer, 0);

    // next_step coinciding with an accepted event.
    check("sim_syn_rdy", {31'd0, syn_rdy}, 1);
    syn_addr = 8'd42; syn_weight = 8'sd6; syn_vld = 1'b1; next_step = 1'b1;
    tick;
    syn_vld = 1'b0; next_step = 1'b0;
    drain(2000);
    check("sim_count", n_xfer, 1);
    check("sim_addr", got_addr[0], 42);
    check("sim_charge", got_chg[0], 6);

    // Clear while a charge is being offered.
    neuron_rdy = 1'b0;
    send(8'd60, 8'sd5);
    pulse_step;
    wait_vld;
    clear_act = 1'b1;
    tick;
    check("clr_vld_drop", {31'd0, neuron_vld}, 0);
    do_clear(256);
    neuron_rdy = 1'b1;
    pulse_step;
    drain(2000);
    check("clr_after_count", n_xfer, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
